// File: rtl/golden_seq_ctrl_pkg.sv
// Shared types and constants for the golden reference sequencer.
package acm_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

    // All-ones source for the saturating error counter; sliced to ERR_WIDTH (<= 32).
    localparam logic [31:0] ERR_SAT = '1;

    localparam int CYCLE_WIDTH = 16;

endpackage

// File: rtl/golden_seq_ctrl_if.sv
// Config/handshake/compare bundle for golden_seq_ctrl.
// ERROR_LOG_EN adds the first-mismatch capture outputs.
interface golden_seq_ctrl_if
    import acm_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DWELL_WIDTH = 3,
    parameter int ROUND_WIDTH = 8,
    parameter int ERR_WIDTH   = 16
);
    logic                   i_Start;
    logic                   i_Abort;
    logic [DWELL_WIDTH-1:0] i_Dwell;
    logic [DATA_WIDTH-1:0]  i_Wrap_Value;
    logic [ROUND_WIDTH-1:0] i_Rounds;
    logic [DATA_WIDTH-1:0]  i_Observed_Data;
    logic                   i_Observed_Valid;
    logic [DATA_WIDTH-1:0]  o_Golden_Data;
    logic                   o_Golden_Valid;
    logic                   o_Busy;
    logic                   o_Done;
    logic                   o_Error;
    logic [ERR_WIDTH-1:0]   o_Error_Count;
`ifdef ERROR_LOG_EN
    logic [DATA_WIDTH-1:0]  o_First_Err_Golden;
    logic [DATA_WIDTH-1:0]  o_First_Err_Observed;
    logic [CYCLE_WIDTH-1:0] o_First_Err_Cycle;

    modport master (
        output i_Start, i_Abort, i_Dwell, i_Wrap_Value, i_Rounds,
               i_Observed_Data, i_Observed_Valid,
        input  o_Golden_Data, o_Golden_Valid, o_Busy, o_Done, o_Error, o_Error_Count,
               o_First_Err_Golden, o_First_Err_Observed, o_First_Err_Cycle
    );
    modport slave (
        input  i_Start, i_Abort, i_Dwell, i_Wrap_Value, i_Rounds,
               i_Observed_Data, i_Observed_Valid,
        output o_Golden_Data, o_Golden_Valid, o_Busy, o_Done, o_Error, o_Error_Count,
               o_First_Err_Golden, o_First_Err_Observed, o_First_Err_Cycle
    );
`else
    modport master (
        output i_Start, i_Abort, i_Dwell, i_Wrap_Value, i_Rounds,
               i_Observed_Data, i_Observed_Valid,
        input  o_Golden_Data, o_Golden_Valid, o_Busy, o_Done, o_Error, o_Error_Count
    );
    modport slave (
        input  i_Start, i_Abort, i_Dwell, i_Wrap_Value, i_Rounds,
               i_Observed_Data, i_Observed_Valid,
        output o_Golden_Data, o_Golden_Valid, o_Busy, o_Done, o_Error, o_Error_Count
    );
`endif

endinterface

// File: rtl/golden_seq_ctrl_step_counter.sv
// Golden pattern generator: dwell counter, value counter 0..wrap, round counter.
// `last` flags the final dwell cycle of the wrap value in the final round.
module golden_step_counter #(
    parameter int DATA_WIDTH  = 8,
    parameter int DWELL_WIDTH = 3,
    parameter int ROUND_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   enable,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic [DATA_WIDTH-1:0]  wrap,
    input  logic [ROUND_WIDTH-1:0] rounds,
    output logic [DATA_WIDTH-1:0]  value,
    output logic                   last
);

    localparam logic [ROUND_WIDTH:0] ROUND_ONE = 1;

    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [ROUND_WIDTH-1:0] round_cnt;
    logic                   dwell_end;
    logic [ROUND_WIDTH:0]   round_plus1;

    assign dwell_end   = (dwell_cnt == dwell);
    // Extra bit keeps rounds == all-ones from aliasing to round 0.
    assign round_plus1 = {1'b0, round_cnt} + ROUND_ONE;
    assign last        = dwell_end && (value == wrap) && (round_plus1 == {1'b0, rounds});

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            value     <= '0;
            round_cnt <= '0;
        end else if (load) begin
            dwell_cnt <= '0;
            value     <= '0;
            round_cnt <= '0;
        end else if (enable) begin
            if (dwell_end) begin
                dwell_cnt <= '0;
                if (value == wrap) begin
                    value     <= '0;
                    round_cnt <= round_plus1[ROUND_WIDTH-1:0];
                end else begin
                    value <= value + DATA_WIDTH'(1);
                end
            end else begin
                dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/golden_seq_ctrl.sv
// Start/abort/done sequencer for the golden reference counter with a same-cycle
// observed-vs-golden comparator. ERROR_LOG_EN enables first-mismatch capture.
module golden_seq_ctrl
    import acm_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DWELL_WIDTH = 3,
    parameter int ROUND_WIDTH = 8,
    parameter int ERR_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           rst,
    golden_seq_ctrl_if.slave bus
);

    seq_state_t             state;
    logic                   busy_q, golden_valid_q, done_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [DATA_WIDTH-1:0]  wrap_q;
    logic [ROUND_WIDTH-1:0] rounds_q;
    logic                   err_q;
    logic [ERR_WIDTH-1:0]   err_cnt_q;
    logic [DATA_WIDTH-1:0]  golden;
    logic                   last;
    logic                   accept, abort_any, mismatch;

    assign accept    = (state == IDLE) && bus.i_Start && !bus.i_Abort;
    assign abort_any = (state != IDLE) && bus.i_Abort;
    assign mismatch  = (state == RUN) && bus.i_Observed_Valid && (bus.i_Observed_Data != golden);

    golden_step_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .DWELL_WIDTH(DWELL_WIDTH),
        .ROUND_WIDTH(ROUND_WIDTH)
    ) u_step (
        .clk   (clk),
        .rst   (rst),
        .load  ((state == LOAD) || abort_any),
        .enable(state == RUN),
        .dwell (dwell_q),
        .wrap  (wrap_q),
        .rounds(rounds_q),
        .value (golden),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            golden_valid_q <= 1'b0;
            done_q         <= 1'b0;
            dwell_q        <= '0;
            wrap_q         <= '0;
            rounds_q       <= '0;
        end else if (abort_any) begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            golden_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state    <= LOAD;
                    busy_q   <= 1'b1;
                    dwell_q  <= bus.i_Dwell;
                    wrap_q   <= bus.i_Wrap_Value;
                    rounds_q <= bus.i_Rounds;
                end
                LOAD: if (rounds_q == '0) begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    state          <= RUN;
                    golden_valid_q <= 1'b1;
                end
                RUN: if (last) begin
                    state          <= DONE;
                    busy_q         <= 1'b0;
                    golden_valid_q <= 1'b0;
                    done_q         <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (accept) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (mismatch) begin
            err_q <= 1'b1;
            if (err_cnt_q != ERR_SAT[ERR_WIDTH-1:0])
                err_cnt_q <= err_cnt_q + ERR_WIDTH'(1);
        end
    end

`ifdef ERROR_LOG_EN
    logic [CYCLE_WIDTH-1:0] run_cycle_q;
    logic [DATA_WIDTH-1:0]  first_golden_q, first_obs_q;
    logic [CYCLE_WIDTH-1:0] first_cycle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycle_q    <= '0;
            first_golden_q <= '0;
            first_obs_q    <= '0;
            first_cycle_q  <= '0;
        end else begin
            if (state == LOAD)
                run_cycle_q <= '0;
            else if (state == RUN)
                run_cycle_q <= run_cycle_q + CYCLE_WIDTH'(1);

            if (accept) begin
                first_golden_q <= '0;
                first_obs_q    <= '0;
                first_cycle_q  <= '0;
            end else if (mismatch && !err_q) begin
                first_golden_q <= golden;
                first_obs_q    <= bus.i_Observed_Data;
                first_cycle_q  <= run_cycle_q;
            end
        end
    end

    assign bus.o_First_Err_Golden   = first_golden_q;
    assign bus.o_First_Err_Observed = first_obs_q;
    assign bus.o_First_Err_Cycle    = first_cycle_q;
`endif

    assign bus.o_Golden_Data  = golden;
    assign bus.o_Golden_Valid = golden_valid_q;
    assign bus.o_Busy         = busy_q;
    assign bus.o_Done         = done_q;
    assign bus.o_Error        = err_q;
    assign bus.o_Error_Count  = err_cnt_q;

endmodule

// File: tb/tb_golden_seq_ctrl.sv
// Directed bench for golden_seq_ctrl; a second instance with ERR_WIDTH=2 shares
// the stimulus to exercise counter saturation. Define ERROR_LOG_EN for log checks.
module tb_golden_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    golden_seq_ctrl_if #(.DATA_WIDTH(8), .DWELL_WIDTH(3), .ROUND_WIDTH(8), .ERR_WIDTH(16)) bus ();
    golden_seq_ctrl_if #(.DATA_WIDTH(8), .DWELL_WIDTH(3), .ROUND_WIDTH(8), .ERR_WIDTH(2))  bus2 ();

    assign bus2.i_Start          = bus.i_Start;
    assign bus2.i_Abort          = bus.i_Abort;
    assign bus2.i_Dwell          = bus.i_Dwell;
    assign bus2.i_Wrap_Value     = bus.i_Wrap_Value;
    assign bus2.i_Rounds         = bus.i_Rounds;
    assign bus2.i_Observed_Data  = bus.i_Observed_Data;
    assign bus2.i_Observed_Valid = bus.i_Observed_Valid;

    golden_seq_ctrl #(.DATA_WIDTH(8), .DWELL_WIDTH(3), .ROUND_WIDTH(8), .ERR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    golden_seq_ctrl #(.DATA_WIDTH(8), .DWELL_WIDTH(3), .ROUND_WIDTH(8), .ERR_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start, check the LOAD cycle, and leave the bench in RUN cycle 0.
    task automatic start_seq(input string tag, input int d, input int w, input int r);
        bus.i_Dwell      = 3'(d);
        bus.i_Wrap_Value = 8'(w);
        bus.i_Rounds     = 8'(r);
        bus.i_Start      = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        check({tag, "_load_busy"},  32'(bus.o_Busy), 32'd1);
        check({tag, "_load_valid"}, 32'(bus.o_Golden_Valid), 32'd0);
        tick();
    endtask

    // RUN cycles k0..k0+n-1; observed follows the model except in [bad_lo, bad_hi].
    task automatic run_phase(input string tag, input int k0, input int n, input int d,
                             input int w, input int bad_lo, input int bad_hi,
                             input logic [7:0] bad_val);
        int exp_g;
        for (int k = k0; k < k0 + n; k++) begin
            exp_g = (k / (d + 1)) % (w + 1);
            check({tag, "_valid"},  32'(bus.o_Golden_Valid), 32'd1);
            check({tag, "_golden"}, 32'(bus.o_Golden_Data), 32'(exp_g));
            bus.i_Observed_Data  = (k >= bad_lo && k <= bad_hi) ? bad_val : 8'(exp_g);
            bus.i_Observed_Valid = 1'b1;
            tick();
        end
        bus.i_Observed_Valid = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},       32'(bus.o_Done), 32'd1);
        check({tag, "_done_valid"}, 32'(bus.o_Golden_Valid), 32'd0);
        check({tag, "_done_busy"},  32'(bus.o_Busy), 32'd0);
        check({tag, "_done_gold"},  32'(bus.o_Golden_Data), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(bus.o_Done), 32'd0);
        check({tag, "_idle_busy"},  32'(bus.o_Busy), 32'd0);
    endtask

    initial begin
        rst                  = 1'b1;
        bus.i_Start          = 1'b0;
        bus.i_Abort          = 1'b0;
        bus.i_Dwell          = '0;
        bus.i_Wrap_Value     = '0;
        bus.i_Rounds         = '0;
        bus.i_Observed_Data  = '0;
        bus.i_Observed_Valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_busy",  32'(bus.o_Busy), 32'd0);
        check("rst_valid", 32'(bus.o_Golden_Valid), 32'd0);
        check("rst_done",  32'(bus.o_Done), 32'd0);
        check("rst_gold",  32'(bus.o_Golden_Data), 32'd0);
        check("rst_err",   32'(bus.o_Error), 32'd0);
        check("rst_cnt",   32'(bus.o_Error_Count), 32'd0);

        // 1: dwell 3, wrap 4, one round, clean compare
        start_seq("t1", 3, 4, 1);
        run_phase("t1", 0, 20, 3, 4, -1, -1, 8'h00);
        check_done("t1");
        check("t1_err", 32'(bus.o_Error), 32'd0);
        check("t1_cnt", 32'(bus.o_Error_Count), 32'd0);

        // 2: dwell 0, wrap 2, three rounds; valid garbage outside RUN is ignored
        bus.i_Observed_Valid = 1'b1;
        bus.i_Observed_Data  = 8'h55;
        tick();
        start_seq("t2", 0, 2, 3);
        run_phase("t2", 0, 9, 0, 2, -1, -1, 8'h00);
        check_done("t2");
        check("t2_err", 32'(bus.o_Error), 32'd0);
        check("t2_cnt", 32'(bus.o_Error_Count), 32'd0);

        // 3: five forced mismatches
        start_seq("t3", 3, 4, 1);
        run_phase("t3", 0, 20, 3, 4, 2, 6, 8'h07);
        check_done("t3");
        check("t3_err",     32'(bus.o_Error), 32'd1);
        check("t3_cnt",     32'(bus.o_Error_Count), 32'd5);
        check("t3_sat_cnt", 32'(bus2.o_Error_Count), 32'd3);

        // 4: zero rounds; accepted start also clears the previous errors
        bus.i_Rounds = 8'd0;
        bus.i_Start  = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        check("t4_busy",  32'(bus.o_Busy), 32'd1);
        check("t4_valid", 32'(bus.o_Golden_Valid), 32'd0);
        check("t4_err",   32'(bus.o_Error), 32'd0);
        check("t4_cnt",   32'(bus.o_Error_Count), 32'd0);
        tick();
        check_done("t4");

        // 5: start pulses during RUN are ignored; abort at RUN cycle 6
        start_seq("t5", 3, 4, 1);
        run_phase("t5", 0, 3, 3, 4, 1, 1, 8'h09);
        bus.i_Start = 1'b1;
        run_phase("t5s", 3, 3, 3, 4, -1, -1, 8'h00);
        bus.i_Start = 1'b0;
        check("t5_k6_gold", 32'(bus.o_Golden_Data), 32'd1);
        bus.i_Abort = 1'b1;
        tick();
        bus.i_Abort = 1'b0;
        check("t5_ab_busy",  32'(bus.o_Busy), 32'd0);
        check("t5_ab_valid", 32'(bus.o_Golden_Valid), 32'd0);
        check("t5_ab_gold",  32'(bus.o_Golden_Data), 32'd0);
        check("t5_ab_done",  32'(bus.o_Done), 32'd0);
        check("t5_ab_err",   32'(bus.o_Error), 32'd1);
        check("t5_ab_cnt",   32'(bus.o_Error_Count), 32'd1);
`ifdef ERROR_LOG_EN
        check("t5_log_cyc", 32'(bus.o_First_Err_Cycle), 32'd1);
        check("t5_log_gld", 32'(bus.o_First_Err_Golden), 32'd0);
        check("t5_log_obs", 32'(bus.o_First_Err_Observed), 32'h09);
`endif
        tick();
        check("t5_no_done", 32'(bus.o_Done), 32'd0);
        bus.i_Start = 1'b1;
        bus.i_Abort = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        bus.i_Abort = 1'b0;
        check("t5_abst_busy", 32'(bus.o_Busy), 32'd0);
        check("t5_abst_err",  32'(bus.o_Error), 32'd1);
        tick();
        check("t5_abst_busy2", 32'(bus.o_Busy), 32'd0);

        // 6: six mismatches from RUN cycle 4; narrow counter saturates
        start_seq("t6", 3, 4, 1);
        check("t6_clr_err", 32'(bus.o_Error), 32'd0);
        run_phase("t6", 0, 20, 3, 4, 4, 9, 8'hA5);
        check_done("t6");
        check("t6_err",     32'(bus.o_Error), 32'd1);
        check("t6_cnt",     32'(bus.o_Error_Count), 32'd6);
        check("t6_sat_err", 32'(bus2.o_Error), 32'd1);
        check("t6_sat_cnt", 32'(bus2.o_Error_Count), 32'd3);
`ifdef ERROR_LOG_EN
        check("t6_log_cyc", 32'(bus.o_First_Err_Cycle), 32'd4);
        check("t6_log_gld", 32'(bus.o_First_Err_Golden), 32'd1);
        check("t6_log_obs", 32'(bus.o_First_Err_Observed), 32'hA5);
`endif

        // 7: asynchronous reset mid-run
        start_seq("t7", 0, 2, 3);
        run_phase("t7", 0, 2, 0, 2, 0, 1, 8'hEE);
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_busy",  32'(bus.o_Busy), 32'd0);
        check("t7_rst_valid", 32'(bus.o_Golden_Valid), 32'd0);
        check("t7_rst_gold",  32'(bus.o_Golden_Data), 32'd0);
        check("t7_rst_err",   32'(bus.o_Error), 32'd0);
        check("t7_rst_cnt",   32'(bus.o_Error_Count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t7_post_busy", 32'(bus.o_Busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
